core_pipe_wback: RTL and testbench
==================================

// Module: core_pipe_wback
// PURPOSE
//  Writeback stage directly downstream of the execute stage; one-entry result register.
//  Retires ALU/CSR results to the GPR file.
//  Waits for the data memory response of loads and stores, then aligns and extends load data.
//  Converts dmem_err into a load or store access-fault trap request toward the control-flow logic.
// PARAMETERS
//  XLEN      64   datapath width; XL = XLEN-1
//  MEM_W     64   dmem_rdata width; byte lanes = MEM_W/8
// PORTS
//  g_clk          in   1     global clock, single clock domain
//  g_reset        in   1     asynchronous, active-high reset
//  s3_valid       in   1     execute presents a retiring instruction
//  s3_ready       out  1     writeback accepts this cycle
//  s3_rd          in   5     destination GPR; 0 = no write
//  s3_wdata       in   XLEN  ALU/CSR result; ignored for loads
//  s3_load        in   1     instruction is a load
//  s3_store       in   1     instruction is a store
//  s3_size        in   2     0=byte 1=half 2=word 3=double
//  s3_signed      in   1     load result is sign-extended
//  s3_addr_lo     in   3     dmem_addr[2:0] of the access
//  s3_pc          in   XLEN  PC, used for trap tval/trace
//  dmem_gnt       in   1     memory response valid (>=1 cycle after request)
//  dmem_err       in   1     memory response error, qualified by dmem_gnt
//  dmem_rdata     in   MEM_W memory response data, qualified by dmem_gnt
//  wb_rd_wen      out  1     GPR write enable
//  wb_rd_addr     out  5     GPR write address
//  wb_rd_wdata    out  XLEN  GPR write data
//  wb_retire      out  1     single-cycle pulse per retired instruction
//  wb_trap_valid  out  1     access fault request, held until acked
//  wb_trap_ack    in   1     trap accepted by the control-flow logic
//  wb_trap_cause  out  4     5 = load access fault, 7 = store access fault
//  wb_trap_pc     out  XLEN  PC of the faulting instruction
// BEHAVIOUR
//  Reset (asynchronous, any cycle, including mid-access):
//   - state=IDLE; every output 0 except s3_ready=1.
//   - A dmem response pending at reset is dropped.
//  Accept: s3_valid & s3_ready. Captures all s3_* fields into the result register.
//  FSM states: IDLE, ALU, MEM, TRAP.
//   - IDLE: accept -> MEM if load|store, else ALU.
//   - ALU: result valid this cycle; wb_rd_wen = (rd!=0); wb_retire=1.
//       - Accept -> ALU/MEM per the new instruction; otherwise -> IDLE.
//   - MEM: wait for dmem_gnt; nothing is written while waiting.
//       - gnt & !err: load writes rd (rd!=0), store writes nothing; wb_retire=1 in the gnt cycle.
//         Accept allowed in the same cycle, as in ALU.
//       - gnt & err: no write, no retire; -> TRAP.
//         cause = 5 for a load, 7 for a store; pc latched.
//   - TRAP: wb_trap_valid=1, cause/pc stable until wb_trap_ack -> IDLE. s3_ready=0.
//  s3_ready = IDLE | ALU | (MEM & dmem_gnt & !dmem_err); combinational, no dependency on s3_valid.
//  Completion latency: 1 cycle after accept for ALU; for memory ops, the cycle dmem_gnt is seen.
//  Throughput: 1 instruction/cycle for back-to-back ALU operations.
//  Write-port outputs are combinational from the result register (plus dmem_rdata for loads).
//   - Don't-care when wb_rd_wen=0, but hold the last value, no X.
//  Load alignment:
//   - shift dmem_rdata right by 8*addr_lo;
//   - keep 8/16/32/64 bits per size;
//   - sign-extend or zero-extend per s3_signed.
//  Misaligned addr_lo for the given size is flagged upstream; this stage uses addr_lo without checks.
//  Simultaneous events:
//   - gnt+err while s3_valid=1: the new instruction is not accepted.
//   - wb_trap_ack outside TRAP is ignored.
//   - dmem_gnt outside MEM is ignored.
// STRUCTURE
//  core_common.vh additions:
//   - LSU_SIZE_B/H/W/D encodings;
//   - CF_CAUSE_LOAD_FAULT=5, CF_CAUSE_STORE_FAULT=7;
//   - WB_ST_IDLE/ALU/MEM/TRAP state encodings.
//  Sub-module core_lsu_align: purely combinational {rdata, addr_lo, size, signed} -> XLEN result.
//  Top level holds the FSM, the result register and the output muxing.
// TESTING
//  1. Reset mid-MEM, then gnt arrives:
//     -> no wen, no retire; s3_ready=1; all outputs 0.
//  2. Back-to-back ALU ops, rd=5 wdata=0x11, then rd=6 wdata=0x22, s3_valid held high:
//     -> wen on consecutive cycles; s3_ready never drops.
//  3. ALU op with rd=0:
//     -> wb_rd_wen=0 and wb_retire=1.
//  4. lb addr_lo=3 signed, rdata=0x0000_0000_8000_0000, gnt after 3 cycles:
//     -> s3_ready=0 for 3 cycles; then wen with wdata=0xFFFF_FFFF_FFFF_FF80.
//     Repeat as lbu -> wdata=0x80.
//  5. ld addr_lo=0, rdata=0x0123_4567_89AB_CDEF -> wdata equals rdata.
//     lhu addr_lo=6 -> wdata=0x0123.
//  6. Store with gnt & err:
//     -> trap_valid with cause=7 and trap_pc=s3_pc; held 4 cycles until ack.
//     -> then IDLE; no wen or retire at any point.

Source files
------------

// File: rtl/core_pipe_wback_pkg.sv
// Shared encodings for the writeback stage: LSU access sizes, trap causes, FSM states
// and the control half of the one-entry result register.
package core_pipe_wback_pkg;

   localparam logic [1:0] LSU_SIZE_B = 2'd0;
   localparam logic [1:0] LSU_SIZE_H = 2'd1;
   localparam logic [1:0] LSU_SIZE_W = 2'd2;
   localparam logic [1:0] LSU_SIZE_D = 2'd3;

   localparam logic [3:0] CF_CAUSE_LOAD_FAULT  = 4'd5;
   localparam logic [3:0] CF_CAUSE_STORE_FAULT = 4'd7;

   localparam logic [1:0] WB_ST_IDLE = 2'd0;
   localparam logic [1:0] WB_ST_ALU  = 2'd1;
   localparam logic [1:0] WB_ST_MEM  = 2'd2;
   localparam logic [1:0] WB_ST_TRAP = 2'd3;

   typedef struct packed {
      logic [4:0] rd;
      logic       load;
      logic       store;
      logic [1:0] size;
      logic       is_signed;
      logic [2:0] addr_lo;
   } wb_ctrl_t;

endpackage

// File: rtl/core_pipe_wback_if.sv
// Execute-to-writeback handshake, dmem response, GPR write port and trap request bundle.
// The slave modport is the writeback stage's view.
interface core_pipe_wback_if #(
   parameter int XLEN  = 64,
   parameter int MEM_W = 64
);
   logic             s3_valid;
   logic             s3_ready;
   logic [4:0]       s3_rd;
   logic [XLEN-1:0]  s3_wdata;
   logic             s3_load;
   logic             s3_store;
   logic [1:0]       s3_size;
   logic             s3_signed;
   logic [2:0]       s3_addr_lo;
   logic [XLEN-1:0]  s3_pc;

   logic             dmem_gnt;
   logic             dmem_err;
   logic [MEM_W-1:0] dmem_rdata;

   logic             wb_rd_wen;
   logic [4:0]       wb_rd_addr;
   logic [XLEN-1:0]  wb_rd_wdata;
   logic             wb_retire;

   logic             wb_trap_valid;
   logic             wb_trap_ack;
   logic [3:0]       wb_trap_cause;
   logic [XLEN-1:0]  wb_trap_pc;

   modport slave (
      input  s3_valid, s3_rd, s3_wdata, s3_load, s3_store, s3_size, s3_signed,
             s3_addr_lo, s3_pc, dmem_gnt, dmem_err, dmem_rdata, wb_trap_ack,
      output s3_ready, wb_rd_wen, wb_rd_addr, wb_rd_wdata, wb_retire,
             wb_trap_valid, wb_trap_cause, wb_trap_pc
   );

   modport master (
      output s3_valid, s3_rd, s3_wdata, s3_load, s3_store, s3_size, s3_signed,
             s3_addr_lo, s3_pc, dmem_gnt, dmem_err, dmem_rdata, wb_trap_ack,
      input  s3_ready, wb_rd_wen, wb_rd_addr, wb_rd_wdata, wb_retire,
             wb_trap_valid, wb_trap_cause, wb_trap_pc
   );

endinterface

// File: rtl/core_pipe_wback_lsu_align.sv
// Load data alignment: shift the memory word down to the accessed byte lane, then
// truncate to the access size and sign- or zero-extend to XLEN. Purely combinational.
module core_pipe_wback_lsu_align
   import core_pipe_wback_pkg::*;
#(
   parameter int XLEN  = 64,
   parameter int MEM_W = 64
) (
   input  logic [MEM_W-1:0] rdata,
   input  logic [2:0]       addr_lo,
   input  logic [1:0]       size,
   input  logic             is_signed,
   output logic [XLEN-1:0]  result
);

   logic [MEM_W-1:0] shifted;

   always_comb begin
      shifted = rdata >> {addr_lo, 3'b000};
      case (size)
         LSU_SIZE_B: result = {{(XLEN-8){is_signed & shifted[7]}},   shifted[7:0]};
         LSU_SIZE_H: result = {{(XLEN-16){is_signed & shifted[15]}}, shifted[15:0]};
         LSU_SIZE_W: result = {{(XLEN-32){is_signed & shifted[31]}}, shifted[31:0]};
         default:    result = shifted[XLEN-1:0];
      endcase
   end

endmodule

// File: rtl/core_pipe_wback.sv
// Writeback stage: one-entry result register feeding the GPR write port, waits on the
// dmem response for loads/stores, and raises an access-fault trap on dmem_err.
module core_pipe_wback
   import core_pipe_wback_pkg::*;
#(
   parameter int XLEN  = 64,
   parameter int MEM_W = 64
) (
   input  logic                 g_clk,
   input  logic                 g_reset,
   core_pipe_wback_if.slave     bus
);

   logic [1:0]      state;
   logic [1:0]      state_nxt;
   wb_ctrl_t        ctrl;
   logic [XLEN-1:0] wdata_q;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] load_result;
   logic            accept;
   logic            mem_done;
   logic            mem_fault;
   logic            in_trap;

   core_pipe_wback_lsu_align #(
      .XLEN  (XLEN),
      .MEM_W (MEM_W)
   ) u_align (
      .rdata     (bus.dmem_rdata),
      .addr_lo   (ctrl.addr_lo),
      .size      (ctrl.size),
      .is_signed (ctrl.is_signed),
      .result    (load_result)
   );

   always_comb begin
      // NOTE: every signal gets a default before any branch so no latch is inferred.
      state_nxt    = state;
      mem_done     = (state == WB_ST_MEM) & bus.dmem_gnt & ~bus.dmem_err;
      mem_fault    = (state == WB_ST_MEM) & bus.dmem_gnt &  bus.dmem_err;
      bus.s3_ready = (state == WB_ST_IDLE) | (state == WB_ST_ALU) | mem_done;
      accept       = bus.s3_valid & bus.s3_ready;

      if (accept)
         state_nxt = (bus.s3_load | bus.s3_store) ? WB_ST_MEM : WB_ST_ALU;
      else if ((state == WB_ST_ALU) || mem_done)
         state_nxt = WB_ST_IDLE;
      else if (mem_fault)
         state_nxt = WB_ST_TRAP;
      else if ((state == WB_ST_TRAP) && bus.wb_trap_ack)
         state_nxt = WB_ST_IDLE;
   end

   always_comb begin
      in_trap           = (state == WB_ST_TRAP);
      bus.wb_retire     = (state == WB_ST_ALU) | mem_done;
      bus.wb_rd_wen     = (ctrl.rd != 5'd0) &
                          ((state == WB_ST_ALU) | (mem_done & ctrl.load));
      bus.wb_rd_addr    = ctrl.rd;
      bus.wb_rd_wdata   = ctrl.load ? load_result : wdata_q;
      bus.wb_trap_valid = in_trap;
      bus.wb_trap_cause = in_trap ? (ctrl.store ? CF_CAUSE_STORE_FAULT : CF_CAUSE_LOAD_FAULT)
                                  : 4'd0;
      bus.wb_trap_pc    = in_trap ? pc_q : '0;
   end

   // NOTE: the result register is reset too, so the write-port outputs read 0 (never X)
   // after reset; a dmem response that was pending is forgotten with the state.
   always_ff @(posedge g_clk or posedge g_reset) begin
      if (g_reset) begin
         state   <= WB_ST_IDLE;
         ctrl    <= '0;
         wdata_q <= '0;
         pc_q    <= '0;
      end else begin
         // NOTE: non-blocking assignments so all registers update from pre-edge values.
         state <= state_nxt;
         if (accept) begin
            ctrl.rd        <= bus.s3_rd;
            ctrl.load      <= bus.s3_load;
            ctrl.store     <= bus.s3_store;
            ctrl.size      <= bus.s3_size;
            ctrl.is_signed <= bus.s3_signed;
            ctrl.addr_lo   <= bus.s3_addr_lo;
            wdata_q        <= bus.s3_wdata;
            pc_q           <= bus.s3_pc;
         end
      end
   end

endmodule

// File: tb/tb_core_pipe_wback.sv
// Bench for core_pipe_wback: directed scenarios with literal expectations, then random
// traffic checked every cycle against an instruction-occupancy model of the stage.
module tb_core_pipe_wback;

   localparam int XLEN  = 64;
   localparam int MEM_W = 64;

   logic g_clk = 1'b0;
   logic g_reset;
   int   n_pass  = 0;
   int   n_total = 0;

   always #5 g_clk = ~g_clk;

   core_pipe_wback_if #(.XLEN(XLEN), .MEM_W(MEM_W)) bus ();

   core_pipe_wback #(.XLEN(XLEN), .MEM_W(MEM_W)) dut (
      .g_clk   (g_clk),
      .g_reset (g_reset),
      .bus     (bus)
   );

   // kind: 0 = ALU, 1 = load, 2 = store
   typedef struct {
      logic [4:0]  rd;
      logic [63:0] wdata;
      int          kind;
      logic [1:0]  size;
      bit          sgn;
      logic [2:0]  alo;
      logic [63:0] pc;
   } inst_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      else
         n_pass++;
   endtask

   function automatic logic [63:0] model_load(logic [63:0] rdata, int a, int sz, bit sgn);
      int          bits = 8 << sz;
      logic [63:0] mask;
      logic [63:0] v = rdata >> (8 * a);
      if (bits < 64) begin
         mask = (64'd1 << bits) - 64'd1;
         v = v & mask;
         if (sgn && v[bits-1]) v = v | ~mask;
      end
      return v;
   endfunction

   task automatic step();
      @(posedge g_clk);
      #1;
   endtask

   task automatic sample();
      @(negedge g_clk);
   endtask

   task automatic clear_inputs();
      bus.s3_valid    = 1'b0;
      bus.s3_rd       = '0;
      bus.s3_wdata    = '0;
      bus.s3_load     = 1'b0;
      bus.s3_store    = 1'b0;
      bus.s3_size     = '0;
      bus.s3_signed   = 1'b0;
      bus.s3_addr_lo  = '0;
      bus.s3_pc       = '0;
      bus.dmem_gnt    = 1'b0;
      bus.dmem_err    = 1'b0;
      bus.dmem_rdata  = '0;
      bus.wb_trap_ack = 1'b0;
   endtask

   task automatic put(input inst_t i);
      bus.s3_valid   = 1'b1;
      bus.s3_rd      = i.rd;
      bus.s3_wdata   = i.wdata;
      bus.s3_load    = (i.kind == 1);
      bus.s3_store   = (i.kind == 2);
      bus.s3_size    = i.size;
      bus.s3_signed  = i.sgn;
      bus.s3_addr_lo = i.alo;
      bus.s3_pc      = i.pc;
   endtask

   function automatic inst_t mk(int kind, logic [4:0] rd, logic [63:0] wdata, logic [1:0] size,
                                bit sgn, logic [2:0] alo, logic [63:0] pc);
      inst_t i;
      i.kind = kind; i.rd = rd; i.wdata = wdata; i.size = size;
      i.sgn = sgn; i.alo = alo; i.pc = pc;
      return i;
   endfunction

   // Directed load/store with a literal expected write value.
   task automatic mem_op(input string nm, input inst_t i, input int waits,
                         input logic [63:0] rdata, input logic [63:0] exp);
      step(); clear_inputs(); put(i);
      sample(); check({nm, "_ready_idle"}, bus.s3_ready, 1);
      step(); bus.s3_valid = 1'b0;
      for (int w = 0; w < waits; w++) begin
         sample();
         check({nm, "_ready_wait"}, bus.s3_ready, 0);
         check({nm, "_wen_wait"}, bus.wb_rd_wen, 0);
         step();
      end
      bus.dmem_gnt = 1'b1; bus.dmem_rdata = rdata;
      sample();
      check({nm, "_wen"}, bus.wb_rd_wen, 1);
      check({nm, "_wdata"}, bus.wb_rd_wdata, exp);
      check({nm, "_retire"}, bus.wb_retire, 1);
      check({nm, "_ready_gnt"}, bus.s3_ready, 1);
   endtask

   // Model state: the instruction occupying writeback and whether it is parked on a trap.
   bit    m_have;
   bit    m_trap;
   inst_t m_inst;

   task automatic random_cycle();
      inst_t n;
      bit    e_ready, e_retire, e_wen, accepted;
      logic [63:0] e_data;
      n = mk($urandom_range(0, 2), ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
             {$urandom, $urandom}, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             3'($urandom_range(0, 7)), {$urandom, $urandom});
      clear_inputs();
      put(n);
      bus.s3_valid    = ($urandom_range(0, 9) < 7);
      bus.dmem_gnt    = ($urandom_range(0, 2) == 0);
      bus.dmem_err    = ($urandom_range(0, 4) == 0);
      bus.dmem_rdata  = {$urandom, $urandom};
      bus.wb_trap_ack = ($urandom_range(0, 3) == 0);

      sample();
      e_ready = 1; e_retire = 0; e_wen = 0; e_data = '0;
      if (m_trap) begin
         e_ready = 0;
      end else if (m_have && m_inst.kind == 0) begin
         e_retire = 1; e_wen = (m_inst.rd != 0); e_data = m_inst.wdata;
      end else if (m_have) begin
         e_ready = bus.dmem_gnt && !bus.dmem_err;
         if (e_ready) begin
            e_retire = 1;
            e_wen    = (m_inst.kind == 1) && (m_inst.rd != 0);
            e_data   = model_load(bus.dmem_rdata, m_inst.alo, m_inst.size, m_inst.sgn);
         end
      end
      check("rnd_ready", bus.s3_ready, e_ready);
      check("rnd_retire", bus.wb_retire, e_retire);
      check("rnd_wen", bus.wb_rd_wen, e_wen);
      check("rnd_wdata_known", $isunknown(bus.wb_rd_wdata), 0);
      check("rnd_trap_valid", bus.wb_trap_valid, m_trap);
      if (e_wen) begin
         check("rnd_addr", bus.wb_rd_addr, m_inst.rd);
         check("rnd_wdata", bus.wb_rd_wdata, e_data);
      end
      if (m_trap) begin
         check("rnd_cause", bus.wb_trap_cause, (m_inst.kind == 1) ? 5 : 7);
         check("rnd_trap_pc", bus.wb_trap_pc, m_inst.pc);
      end

      accepted = bus.s3_valid && e_ready;
      if (m_trap) begin
         if (bus.wb_trap_ack) begin m_trap = 0; m_have = 0; end
      end else if (m_have && m_inst.kind != 0 && bus.dmem_gnt && bus.dmem_err) begin
         m_trap = 1;
      end else if (accepted) begin
         m_have = 1; m_inst = n;
      end else if (m_have && (m_inst.kind == 0 || bus.dmem_gnt)) begin
         m_have = 0;
      end
      step();
   endtask

   initial begin
      g_reset = 1'b1;
      clear_inputs();
      repeat (2) @(posedge g_clk);
      #1 g_reset = 1'b0;

      // Reset values, then reset while a load waits for its response.
      sample();
      check("rst_ready", bus.s3_ready, 1);
      check("rst_wen", bus.wb_rd_wen, 0);
      check("rst_retire", bus.wb_retire, 0);
      check("rst_trap_valid", bus.wb_trap_valid, 0);
      check("rst_cause", bus.wb_trap_cause, 0);
      check("rst_trap_pc", bus.wb_trap_pc, 0);
      check("rst_addr", bus.wb_rd_addr, 0);
      check("rst_wdata", bus.wb_rd_wdata, 0);
      step(); put(mk(1, 5'd7, 64'h0, 2'd3, 0, 3'd0, 64'h40));
      sample();
      step(); bus.s3_valid = 1'b0;
      sample(); check("midmem_ready", bus.s3_ready, 0);
      step();
      g_reset = 1'b1; #1 g_reset = 1'b0;
      bus.dmem_gnt = 1'b1; bus.dmem_rdata = '1;
      sample();
      check("rstmem_wen", bus.wb_rd_wen, 0);
      check("rstmem_retire", bus.wb_retire, 0);
      check("rstmem_ready", bus.s3_ready, 1);
      check("rstmem_addr", bus.wb_rd_addr, 0);
      check("rstmem_wdata", bus.wb_rd_wdata, 0);
      check("rstmem_trap", bus.wb_trap_valid, 0);

      // Back-to-back ALU ops with s3_valid held high.
      step(); clear_inputs(); put(mk(0, 5'd5, 64'h11, 2'd0, 0, 3'd0, 64'h100));
      sample(); check("b2b_ready0", bus.s3_ready, 1);
      step(); put(mk(0, 5'd6, 64'h22, 2'd0, 0, 3'd0, 64'h104));
      sample();
      check("b2b_wen1", bus.wb_rd_wen, 1);
      check("b2b_addr1", bus.wb_rd_addr, 5);
      check("b2b_wdata1", bus.wb_rd_wdata, 64'h11);
      check("b2b_retire1", bus.wb_retire, 1);
      check("b2b_ready1", bus.s3_ready, 1);
      step(); bus.s3_valid = 1'b0;
      sample();
      check("b2b_wen2", bus.wb_rd_wen, 1);
      check("b2b_addr2", bus.wb_rd_addr, 6);
      check("b2b_wdata2", bus.wb_rd_wdata, 64'h22);
      check("b2b_ready2", bus.s3_ready, 1);
      step();
      sample();
      check("b2b_idle_wen", bus.wb_rd_wen, 0);
      check("b2b_idle_retire", bus.wb_retire, 0);

      // ALU op to x0 retires without a write.
      step(); put(mk(0, 5'd0, 64'h33, 2'd0, 0, 3'd0, 64'h108));
      sample();
      step(); bus.s3_valid = 1'b0;
      sample();
      check("x0_wen", bus.wb_rd_wen, 0);
      check("x0_retire", bus.wb_retire, 1);

      // Load alignment cases.
      mem_op("lb",  mk(1, 5'd9, 64'h0, 2'd0, 1, 3'd3, 64'h200), 3,
             64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80);
      mem_op("lbu", mk(1, 5'd9, 64'h0, 2'd0, 0, 3'd3, 64'h204), 3,
             64'h0000_0000_8000_0000, 64'h0000_0000_0000_0080);
      mem_op("ld",  mk(1, 5'd10, 64'h0, 2'd3, 0, 3'd0, 64'h208), 1,
             64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);
      mem_op("lhu", mk(1, 5'd11, 64'h0, 2'd1, 0, 3'd6, 64'h20C), 0,
             64'h0123_4567_89AB_CDEF, 64'h0000_0000_0000_0123);

      // Store with an error response becomes a held trap request.
      step(); clear_inputs(); put(mk(2, 5'd4, 64'h55, 2'd3, 0, 3'd0, 64'h8000_1000));
      sample();
      step(); bus.s3_valid = 1'b0;
      sample(); check("st_ready_wait", bus.s3_ready, 0);
      step(); bus.dmem_gnt = 1'b1; bus.dmem_err = 1'b1; bus.s3_valid = 1'b1;
      sample();
      check("sterr_ready", bus.s3_ready, 0);
      check("sterr_wen", bus.wb_rd_wen, 0);
      check("sterr_retire", bus.wb_retire, 0);
      step(); bus.dmem_gnt = 1'b0; bus.dmem_err = 1'b0; bus.s3_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (k == 3) bus.wb_trap_ack = 1'b1;
         sample();
         check("trap_valid", bus.wb_trap_valid, 1);
         check("trap_cause", bus.wb_trap_cause, 7);
         check("trap_pc", bus.wb_trap_pc, 64'h8000_1000);
         check("trap_ready", bus.s3_ready, 0);
         check("trap_wen", bus.wb_rd_wen, 0);
         check("trap_retire", bus.wb_retire, 0);
         step();
      end
      bus.wb_trap_ack = 1'b0;
      sample();
      check("post_trap_valid", bus.wb_trap_valid, 0);
      check("post_trap_ready", bus.s3_ready, 1);
      check("post_trap_retire", bus.wb_retire, 0);

      // Random traffic against the model.
      step();
      g_reset = 1'b1; clear_inputs();
      step();
      g_reset = 1'b0;
      m_have = 0; m_trap = 0;
      m_inst = mk(0, 5'd0, 64'h0, 2'd0, 0, 3'd0, 64'h0);
      for (int c = 0; c < 3000; c++) random_cycle();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
